// File: rtl/pwm_ramp_ctrl_if.sv
// Duty-target handshake between a target source and pwm_ramp_ctrl.
// The source drives tgt/tgt_valid; the controller answers with tgt_ready.
interface pwm_ramp_ctrl_if #(
    parameter int W = 8
);
    logic [W-1:0] tgt;
    logic         tgt_valid;
    logic         tgt_ready;

    modport master (
        output tgt,
        output tgt_valid,
        input  tgt_ready
    );

    modport slave (
        input  tgt,
        input  tgt_valid,
        output tgt_ready
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop duty scheduler: ramps the Pwm duty word toward a target by STEP
// every PERIODS_PER_STEP period carry-outs, with a latching fault that forces duty to 0.

module pwm_ramp_ctrl_chk #(
    parameter int W     = 8,
    parameter int DIV_W = 1,
    parameter int PPS   = 1
) (
    input logic             clk,
    input logic             rst,
    input logic             co,
    input logic             fault,
    input logic [1:0]       state,
    input logic [W-1:0]     duty,
    input logic [DIV_W-1:0] div_cnt,
    input logic             busy
);
    logic [W-1:0] prev_duty_r;
    logic         prev_ok_r;
    logic         armed_r;

    // Remember what the previous edge was allowed to do to duty.
    always_ff @(posedge clk) begin
        prev_duty_r <= duty;
        prev_ok_r   <= rst | fault | ((state == 2'd1) & co);
        armed_r     <= 1'b1;
    end

    // Invariants of the registered state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_fault_zero: assert (state != 2'd3 || duty == {W{1'b0}});
            a_div_idle:   assert (state == 2'd1 || div_cnt == {DIV_W{1'b0}});
            a_div_range:  assert (int'(div_cnt) < PPS);
            a_busy:       assert (busy == (state == 2'd1));
            if (armed_r && (duty != prev_duty_r)) begin
                a_duty_src: assert (prev_ok_r);
            end
        end
    end
endmodule

module pwm_ramp_ctrl #(
    parameter int W                = 8,
    parameter int STEP             = 1,
    parameter int PERIODS_PER_STEP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    pwm_ramp_ctrl_if.slave        tgt_if,
    input  logic                  co,
    input  logic                  fault,
    input  logic                  fault_clr,
    output logic [W-1:0]          duty,
    output logic [1:0]            state,
    output logic                  busy,
    output logic                  at_target
);
    localparam int               DIV_W    = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIODS_PER_STEP - 1);
    localparam logic [W:0]       STEP_X   = (W+1)'(STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RAMP  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    state_e           state_r, state_s;
    logic [W-1:0]     duty_r, duty_s;
    logic [W-1:0]     tgt_r, tgt_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic             rdy_r;
    logic [W-1:0]     eff_tgt_s;
    logic [W-1:0]     step_s;
    logic             tgt_ready_s;
    logic             accept_s;

    // One step toward tgt_v in W+1 bits, so full scale is reachable and nothing wraps.
    function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur,
                                                 input logic [W-1:0] tgt_v);
        logic [W:0] sum_v;
        logic [W:0] diff_v;
        sum_v  = {1'b0, cur} + STEP_X;
        diff_v = {1'b0, cur} - {1'b0, tgt_v};
        if (tgt_v > cur) begin
            if (sum_v >= {1'b0, tgt_v}) begin
                return tgt_v;
            end else begin
                return sum_v[W-1:0];
            end
        end else if (cur > tgt_v) begin
            if (diff_v <= STEP_X) begin
                return tgt_v;
            end else begin
                return cur - STEP_X[W-1:0];
            end
        end else begin
            return cur;
        end
    endfunction

    // Effective target and handshake readiness; rdy_r holds ready low for the cycle rst drops.
    always_comb begin
        eff_tgt_s   = en ? tgt_r : {W{1'b0}};
        tgt_ready_s = rdy_r && (state_r != S_FAULT) && !fault;
        accept_s    = tgt_if.tgt_valid && tgt_ready_s;
        step_s      = step_toward(duty_r, eff_tgt_s);
    end

    assign tgt_if.tgt_ready = tgt_ready_s;

    // Next-state, next-duty, divider and target capture; fault overrides everything.
    always_comb begin
        state_s = state_r;
        duty_s  = duty_r;
        div_s   = div_r;
        if (accept_s) begin
            tgt_s = tgt_if.tgt;
        end else begin
            tgt_s = tgt_r;
        end
        if (fault) begin
            state_s = S_FAULT;
            duty_s  = {W{1'b0}};
            div_s   = {DIV_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    div_s = {DIV_W{1'b0}};
                    if (eff_tgt_s != {W{1'b0}}) begin
                        state_s = S_RAMP;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_RAMP: begin
                    if (duty_r == eff_tgt_s) begin
                        // Retargeted onto the current duty: settle without stepping.
                        div_s   = {DIV_W{1'b0}};
                        state_s = (eff_tgt_s == {W{1'b0}}) ? S_IDLE : S_HOLD;
                    end else if (co) begin
                        if (div_r == DIV_LAST) begin
                            div_s  = {DIV_W{1'b0}};
                            duty_s = step_s;
                            if (step_s == eff_tgt_s) begin
                                state_s = (eff_tgt_s == {W{1'b0}}) ? S_IDLE : S_HOLD;
                            end else begin
                                state_s = S_RAMP;
                            end
                        end else begin
                            div_s = div_r + DIV_W'(1);
                        end
                    end else begin
                        div_s = div_r;
                    end
                end
                S_HOLD: begin
                    div_s = {DIV_W{1'b0}};
                    if (eff_tgt_s != duty_r) begin
                        state_s = S_RAMP;
                    end else begin
                        state_s = S_HOLD;
                    end
                end
                S_FAULT: begin
                    div_s  = {DIV_W{1'b0}};
                    duty_s = {W{1'b0}};
                    if (fault_clr) begin
                        state_s = S_IDLE;
                        tgt_s   = {W{1'b0}};
                    end else begin
                        state_s = S_FAULT;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                    duty_s  = {W{1'b0}};
                    div_s   = {DIV_W{1'b0}};
                end
            endcase
        end
    end

    // State, duty, target and divider registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            duty_r  <= {W{1'b0}};
            tgt_r   <= {W{1'b0}};
            div_r   <= {DIV_W{1'b0}};
            rdy_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            duty_r  <= duty_s;
            tgt_r   <= tgt_s;
            div_r   <= div_s;
            rdy_r   <= 1'b1;
        end
    end

    assign duty      = duty_r;
    assign state     = state_r;
    assign busy      = (state_r == S_RAMP);
    assign at_target = (duty_r == eff_tgt_s) && (state_r != S_FAULT);

    pwm_ramp_ctrl_chk #(
        .W     (W),
        .DIV_W (DIV_W),
        .PPS   (PERIODS_PER_STEP)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .co      (co),
        .fault   (fault),
        .state   (state_r),
        .duty    (duty_r),
        .div_cnt (div_r),
        .busy    (busy)
    );
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: dut1 uses STEP=4 / 2 co per step with co every 16 clk,
// dut2 uses STEP=4 / 1 co per step with co every clk against a small step model.
module tb_pwm_ramp_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         en1, co1, fault1, fault_clr1;
    logic [W-1:0] duty1;
    logic [1:0]   state1;
    logic         busy1, at_target1;
    logic         en2, co2, fault2, fault_clr2;
    logic [W-1:0] duty2;
    logic [1:0]   state2;
    logic         busy2, at_target2;

    int checks   = 0;
    int failures = 0;

    pwm_ramp_ctrl_if #(.W(W)) bus1 ();
    pwm_ramp_ctrl_if #(.W(W)) bus2 ();

    pwm_ramp_ctrl #(.W(W), .STEP(4), .PERIODS_PER_STEP(2)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .tgt_if(bus1), .co(co1), .fault(fault1),
        .fault_clr(fault_clr1), .duty(duty1), .state(state1), .busy(busy1),
        .at_target(at_target1)
    );

    pwm_ramp_ctrl #(.W(W), .STEP(4), .PERIODS_PER_STEP(1)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .tgt_if(bus2), .co(co2), .fault(fault2),
        .fault_clr(fault_clr2), .duty(duty2), .state(state2), .busy(busy2),
        .at_target(at_target2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One PWM period of 16 clk ending with a co pulse on dut1.
    task automatic period1();
        repeat (15) tick();
        co1 = 1'b1;
        tick();
        co1 = 1'b0;
    endtask

    task automatic two_co();
        period1();
        period1();
    endtask

    task automatic accept1(input logic [W-1:0] v);
        bus1.tgt       = v;
        bus1.tgt_valid = 1'b1;
        tick();
        bus1.tgt_valid = 1'b0;
    endtask

    function automatic int nxt(input int d, input int t);
        if (t > d) return (d + 4 >= t) ? t : d + 4;
        else if (d > t) return (d - t <= 4) ? t : d - 4;
        else return d;
    endfunction

    initial begin
        int e;
        rst = 1'b1;
        en1 = 1'b0; co1 = 1'b0; fault1 = 1'b0; fault_clr1 = 1'b0;
        en2 = 1'b1; co2 = 1'b0; fault2 = 1'b0; fault_clr2 = 1'b0;
        bus1.tgt = '0; bus1.tgt_valid = 1'b0;
        bus2.tgt = '0; bus2.tgt_valid = 1'b0;
        tick();
        tick();
        chk("rst_duty", 32'(duty1), 32'd0);
        chk("rst_state", 32'(state1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_at_target", 32'(at_target1), 32'd1);
        chk("rst_ready", 32'(bus1.tgt_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(bus1.tgt_ready), 32'd1);

        // 1: ramp up to 10
        en1 = 1'b1;
        accept1(8'd10);
        chk("t1_idle_after_accept", 32'(state1), 32'd0);
        tick();
        chk("t1_ramp", 32'(state1), 32'd1);
        chk("t1_busy", 32'(busy1), 32'd1);
        chk("t1_not_at_target", 32'(at_target1), 32'd0);
        period1();
        chk("t1_duty_co1", 32'(duty1), 32'd0);
        period1();
        chk("t1_duty_co2", 32'(duty1), 32'd4);
        two_co();
        chk("t1_duty_8", 32'(duty1), 32'd8);
        two_co();
        chk("t1_duty_10", 32'(duty1), 32'd10);
        chk("t1_hold", 32'(state1), 32'd2);
        chk("t1_busy_low", 32'(busy1), 32'd0);
        chk("t1_at_target", 32'(at_target1), 32'd1);

        // 2: soft stop and re-enable
        en1 = 1'b0;
        #1;
        chk("t2_at_target_low", 32'(at_target1), 32'd0);
        tick();
        chk("t2_ramp", 32'(state1), 32'd1);
        two_co();
        chk("t2_duty_6", 32'(duty1), 32'd6);
        two_co();
        chk("t2_duty_2", 32'(duty1), 32'd2);
        two_co();
        chk("t2_duty_0", 32'(duty1), 32'd0);
        chk("t2_idle", 32'(state1), 32'd0);
        en1 = 1'b1;
        tick();
        chk("t2_reramp", 32'(state1), 32'd1);
        two_co();
        chk("t2_back_4", 32'(duty1), 32'd4);
        two_co();
        two_co();
        chk("t2_back_10", 32'(duty1), 32'd10);
        chk("t2_back_hold", 32'(state1), 32'd2);

        // 3: retarget mid-ramp, with one accept coinciding with a stepping co
        accept1(8'd0);
        tick();
        two_co();
        two_co();
        two_co();
        chk("t3_down_0", 32'(duty1), 32'd0);
        chk("t3_idle", 32'(state1), 32'd0);
        accept1(8'd40);
        tick();
        two_co();
        two_co();
        period1();
        chk("t3_duty_8", 32'(duty1), 32'd8);
        repeat (15) tick();
        co1 = 1'b1;
        bus1.tgt = 8'd5;
        bus1.tgt_valid = 1'b1;
        tick();
        co1 = 1'b0;
        bus1.tgt_valid = 1'b0;
        chk("t3_step_old_tgt", 32'(duty1), 32'd12);
        chk("t3_still_ramp", 32'(state1), 32'd1);
        two_co();
        chk("t3_down_8", 32'(duty1), 32'd8);
        two_co();
        chk("t3_sat_5", 32'(duty1), 32'd5);
        chk("t3_hold", 32'(state1), 32'd2);
        chk("t3_at_target", 32'(at_target1), 32'd1);

        // back to 0, then tgt=0 in IDLE must stay IDLE
        accept1(8'd0);
        tick();
        two_co();
        chk("t5_down_1", 32'(duty1), 32'd1);
        two_co();
        chk("t5_down_0", 32'(duty1), 32'd0);
        accept1(8'd0);
        tick();
        chk("t5_zero_idle", 32'(state1), 32'd0);
        chk("t5_zero_busy", 32'(busy1), 32'd0);

        // 4: fault mid-ramp, coinciding with a stepping co
        accept1(8'd40);
        tick();
        two_co();
        two_co();
        period1();
        repeat (15) tick();
        co1 = 1'b1;
        fault1 = 1'b1;
        tick();
        co1 = 1'b0;
        chk("t4_duty_0", 32'(duty1), 32'd0);
        chk("t4_fault", 32'(state1), 32'd3);
        chk("t4_ready_low", 32'(bus1.tgt_ready), 32'd0);
        chk("t4_at_target_low", 32'(at_target1), 32'd0);
        fault_clr1 = 1'b1;
        tick();
        fault_clr1 = 1'b0;
        chk("t4_clr_ignored", 32'(state1), 32'd3);
        fault1 = 1'b0;
        tick();
        chk("t4_latched", 32'(state1), 32'd3);
        chk("t4_ready_still_low", 32'(bus1.tgt_ready), 32'd0);
        fault_clr1 = 1'b1;
        tick();
        fault_clr1 = 1'b0;
        chk("t4_idle", 32'(state1), 32'd0);
        chk("t4_duty_stays_0", 32'(duty1), 32'd0);
        chk("t4_ready_back", 32'(bus1.tgt_ready), 32'd1);
        chk("t4_at_target", 32'(at_target1), 32'd1);
        two_co();
        chk("t4_tgt_cleared", 32'(state1), 32'd0);

        // 5: full scale, no wrap
        accept1(8'd255);
        tick();
        chk("t5_fs_ramp", 32'(state1), 32'd1);
        for (int i = 1; i <= 64; i++) begin
            two_co();
            e = (4 * i > 255) ? 255 : 4 * i;
            chk("t5_fs_duty", 32'(duty1), 32'(e));
        end
        chk("t5_fs_hold", 32'(state1), 32'd2);
        chk("t5_fs_at_target", 32'(at_target1), 32'd1);

        // 5: reset mid-ramp
        accept1(8'd100);
        tick();
        two_co();
        chk("t5_down_251", 32'(duty1), 32'd251);
        period1();
        rst = 1'b1;
        tick();
        chk("t5_rst_duty", 32'(duty1), 32'd0);
        chk("t5_rst_state", 32'(state1), 32'd0);
        chk("t5_rst_busy", 32'(busy1), 32'd0);
        chk("t5_rst_at_target", 32'(at_target1), 32'd1);
        chk("t5_rst_ready", 32'(bus1.tgt_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("t5_rst_ready_back", 32'(bus1.tgt_ready), 32'd1);
        two_co();
        chk("t5_rst_no_step", 32'(duty1), 32'd0);
        chk("t5_rst_idle", 32'(state1), 32'd0);

        // 6: co every clk, one step per clk on dut2
        bus2.tgt = 8'd30;
        bus2.tgt_valid = 1'b1;
        co2 = 1'b1;
        tick();
        bus2.tgt_valid = 1'b0;
        chk("t6_idle", 32'(state2), 32'd0);
        tick();
        chk("t6_ramp", 32'(state2), 32'd1);
        chk("t6_no_step_yet", 32'(duty2), 32'd0);
        e = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            e = nxt(e, 30);
            chk("t6_up_duty", 32'(duty2), 32'(e));
        end
        chk("t6_hold", 32'(state2), 32'd2);
        bus2.tgt = 8'd3;
        bus2.tgt_valid = 1'b1;
        tick();
        bus2.tgt_valid = 1'b0;
        chk("t6_hold_ignores_co", 32'(duty2), 32'd30);
        tick();
        chk("t6_reramp", 32'(state2), 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            e = nxt(e, 3);
            chk("t6_down_duty", 32'(duty2), 32'(e));
        end
        chk("t6_down_end", 32'(duty2), 32'd3);
        chk("t6_hold_end", 32'(state2), 32'd2);
        co2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
